// File: rtl/cpu68k_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpu68k_bus_pkg
// Shared constants for the 68k-style peripheral bus initiator.
//   - FSM state encodings for cpu68k_bus_master (IDLE=0 .. RECOVER=4)
//   - Bus-level polarity constants for dtack and rw
// No ports; imported by cpu68k_bus_master and cpu68k_sync2.
// ---------------------------------------------------------------------------
package cpu68k_bus_pkg;

  // Master FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  // dtack is active low on the bus
  localparam logic DTACK_ASSERTED = 1'b0;

  // Bus direction encoding
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/cpu68k_sync2.sv
// ---------------------------------------------------------------------------
// cpu68k_sync2
// Two-flop synchronizer for signals arriving from a responder that may run
// on an unrelated clock. Output lags input by two clock edges.
// Ports:
//   i_clk   in  1      sampling clock
//   i_rst   in  1      synchronous active-high reset
//   i_d     in  WIDTH  asynchronous input
//   o_q     out WIDTH  synchronized output (RESET_VALUE while in reset)
// ---------------------------------------------------------------------------
module cpu68k_sync2
  import cpu68k_bus_pkg::*;
#(
  parameter int              WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Reset to the idle value so a reset never looks like an acknowledge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/cpu68k_bus_master.sv
// ---------------------------------------------------------------------------
// cpu68k_bus_master
// Initiator for the 68k-style peripheral bus (cs/ds/rw/dtack, 8-bit data).
// Converts single-beat valid/ready requests into bus cycles, waits for the
// active-low dtack, and reports read data or a timeout on a one-cycle
// response strobe. All outputs are registered.
//
// Optional feature: define CPU68K_DTACK_SYNC_EN to pass dtack and bus_in
// through a 2-flop synchronizer (cpu68k_sync2) before use. This adds two
// cycles of acknowledge latency; the timeout still counts raw cycles.
//
// Parameters:
//   SETUP_CYCLES    cycles cs/rw/data are held before ds rises (>= 1)
//   TIMEOUT_CYCLES  max wait cycles for dtack; 0 disables the timeout
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_rw, req_data      request direction (1=read) and write data
//   rsp_valid             one-cycle pulse per completed transaction
//   rsp_data              last read data, held until the next read
//   rsp_timeout           qualifies rsp_valid; 1 = no dtack seen
//   cs, ds, rw            bus control outputs (cs/ds active high)
//   bus_out, bus_oe       write data and its output enable
//   bus_in, dtack         responder data and active-low acknowledge
// ---------------------------------------------------------------------------
module cpu68k_bus_master
  import cpu68k_bus_pkg::*;
#(
  parameter int SETUP_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       cs,
  output logic       ds,
  output logic       rw,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  input  logic       dtack
);

  localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int WAIT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [2:0]         r_state;
  logic [SETUP_W-1:0] r_setupCnt;
  logic [WAIT_W-1:0]  r_waitCnt;
  logic               r_reqReady;
  logic               r_rspValid;
  logic [7:0]         r_rspData;
  logic               r_rspTimeout;
  logic               r_cs;
  logic               r_ds;
  logic               r_rw;
  logic [7:0]         r_busOut;
  logic               r_busOe;

  logic               w_dtack;
  logic [7:0]         w_busIn;
  logic               w_waitExpired;
  logic [WAIT_W-1:0]  w_waitInc;

`ifdef CPU68K_DTACK_SYNC_EN
  // dtack and data travel together so captured data lines up with the ack
  cpu68k_sync2 #(
    .WIDTH       (9),
    .RESET_VALUE (9'h100)
  ) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   ({dtack, bus_in}),
    .o_q   ({w_dtack, w_busIn})
  );
`else
  assign w_dtack = dtack;
  assign w_busIn = bus_in;
`endif

  // The current edge is the TIMEOUT_CYCLES-th waiting edge when the count
  // of previous waiting edges is TIMEOUT_CYCLES-1
  assign w_waitExpired = (TIMEOUT_CYCLES != 0) &&
                         ((int'(r_waitCnt) + 1) >= TIMEOUT_CYCLES);

  // Saturating increment so a disabled timeout never wraps
  assign w_waitInc = (r_waitCnt == '1) ? r_waitCnt : r_waitCnt + WAIT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_setupCnt   <= '0;
      r_waitCnt    <= '0;
      r_reqReady   <= 1'b0;
      r_rspValid   <= 1'b0;
      r_rspData    <= 8'h00;
      r_rspTimeout <= 1'b0;
      r_cs         <= 1'b0;
      r_ds         <= 1'b0;
      r_rw         <= RW_READ;
      r_busOut     <= 8'h00;
      r_busOe      <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_reqReady) begin
            r_reqReady <= 1'b0;
            r_cs       <= 1'b1;
            r_rw       <= req_rw;
            r_busOut   <= req_data;
            r_busOe    <= (req_rw == RW_WRITE);
            r_setupCnt <= '0;
            r_state    <= ST_SETUP;
          end else begin
            r_reqReady <= 1'b1;
          end
        end

        // dtack is deliberately not looked at while setting up
        ST_SETUP: begin
          if (int'(r_setupCnt) >= SETUP_CYCLES - 1) begin
            r_ds      <= 1'b1;
            r_waitCnt <= '0;
            r_state   <= ST_STROBE;
          end else begin
            r_setupCnt <= r_setupCnt + SETUP_W'(1);
          end
        end

        // Acknowledge wins over a timeout landing on the same edge
        ST_STROBE: begin
          if (w_dtack == DTACK_ASSERTED || w_waitExpired) begin
            if (w_dtack == DTACK_ASSERTED) begin
              if (r_rw == RW_READ) begin
                r_rspData <= w_busIn;
              end
              r_rspTimeout <= 1'b0;
            end else begin
              r_rspTimeout <= 1'b1;
            end
            r_cs       <= 1'b0;
            r_ds       <= 1'b0;
            r_busOe    <= 1'b0;
            r_rw       <= RW_READ;
            r_rspValid <= 1'b1;
            r_waitCnt  <= '0;
            r_state    <= ST_RELEASE;
          end else begin
            r_waitCnt <= w_waitInc;
          end
        end

        ST_RELEASE: begin
          if (w_dtack != DTACK_ASSERTED) begin
            r_reqReady <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_state <= ST_RECOVER;
          end
        end

        // A stuck responder is abandoned after the timeout; the response
        // was already issued so nothing further is reported
        ST_RECOVER: begin
          if (w_dtack != DTACK_ASSERTED || w_waitExpired) begin
            r_reqReady <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_waitCnt <= w_waitInc;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_reqReady;
  assign rsp_valid   = r_rspValid;
  assign rsp_data    = r_rspData;
  assign rsp_timeout = r_rspTimeout;
  assign cs          = r_cs;
  assign ds          = r_ds;
  assign rw          = r_rw;
  assign bus_out     = r_busOut;
  assign bus_oe      = r_busOe;

endmodule
